// File: rtl/camera_capture.sv
// rtl/camera_capture.sv - sensor clock generation, input sync and frame-to-RAM byte capture
// Optional feature macro: CAM_CAPTURE_ROW_SKIP_EN (store even rows only)
module camera_capture #(
    parameter int CLK_DIV   = 2,
    parameter int ADDR_W    = 15,
    parameter int MAX_BYTES = 11376
) (
    input  logic              Clk,
    input  logic              i_Rst_n,
    input  logic              i_Enable,
    input  logic              i_PLK,
    input  logic              i_VS,
    input  logic              i_HS,
    input  logic [7:0]        i_D,
    output logic              o_XLK,
    output logic [7:0]        o_Data,
    output logic [ADDR_W-1:0] o_Addr,
    output logic              o_We,
    output logic              o_Frame_Done,
    output logic              o_Overflow
);

    localparam int XW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [XW-1:0]     X_LAST = XW'(CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(MAX_BYTES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

`ifdef CAM_CAPTURE_ROW_SKIP_EN
    localparam int HS_LEN = 3;
`else
    localparam int HS_LEN = 2;
`endif

    logic [XW-1:0]     xlk_cnt;
    logic [2:0]        plk_sr;
    logic [2:0]        vs_sr;
    logic [HS_LEN-1:0] hs_sr;
    logic [7:0]        d_s2;
    logic [7:0]        d_s3;
    logic              pix_stb;
    logic              vs_fall;
    logic              vs_rise;
    logic              pix_ok;
    logic              addr_full;
    logic [1:0]        state;

    always_ff @(posedge Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            xlk_cnt <= '0;
            o_XLK   <= 1'b0;
        end else if (xlk_cnt == X_LAST) begin
            xlk_cnt <= '0;
            o_XLK   <= ~o_XLK;
        end else begin
            xlk_cnt <= xlk_cnt + 1'b1;
        end
    end

    // Stage [1] is the synchronised value, stage [2] the previous one for edge detection.
    always_ff @(posedge Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            plk_sr  <= '0;
            vs_sr   <= '0;
            hs_sr   <= '0;
            d_s2    <= '0;
            d_s3    <= '0;
            pix_stb <= 1'b0;
            vs_fall <= 1'b0;
            vs_rise <= 1'b0;
        end else begin
            plk_sr  <= {plk_sr[1:0], i_PLK};
            vs_sr   <= {vs_sr[1:0], i_VS};
            hs_sr   <= {hs_sr[HS_LEN-2:0], i_HS};
            d_s2    <= i_D;
            d_s3    <= d_s2;
            pix_stb <= plk_sr[1] & ~plk_sr[2] & hs_sr[1];
            vs_fall <= ~vs_sr[1] & vs_sr[2];
            vs_rise <= vs_sr[1] & ~vs_sr[2];
        end
    end

`ifdef CAM_CAPTURE_ROW_SKIP_EN
    logic hs_fall;
    logic row_odd;

    always_ff @(posedge Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            hs_fall <= 1'b0;
            row_odd <= 1'b0;
        end else begin
            hs_fall <= ~hs_sr[1] & hs_sr[2];
            if (state == S_IDLE && i_Enable && vs_fall) begin
                row_odd <= 1'b0;
            end else if (hs_fall) begin
                row_odd <= ~row_odd;
            end
        end
    end

    assign pix_ok = pix_stb & ~row_odd;
`else
    assign pix_ok = pix_stb;
`endif

    always_ff @(posedge Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state        <= S_IDLE;
            o_Data       <= '0;
            o_Addr       <= '0;
            o_We         <= 1'b0;
            o_Frame_Done <= 1'b0;
            o_Overflow   <= 1'b0;
            addr_full    <= 1'b0;
        end else begin
            o_We         <= 1'b0;
            o_Frame_Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_Addr    <= '0;
                    addr_full <= 1'b0;
                    if (i_Enable && vs_fall) begin
                        state      <= S_CAPTURE;
                        o_Overflow <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    if (!i_Enable) begin
                        state  <= S_IDLE;
                        o_Addr <= '0;
                    end else begin
                        // Address saturates at the last slot; a flag marks it as consumed.
                        if (o_We) begin
                            if (o_Addr == A_LAST) begin
                                addr_full <= 1'b1;
                            end else begin
                                o_Addr <= o_Addr + 1'b1;
                            end
                        end
                        if (pix_ok) begin
                            if (addr_full) begin
                                o_Overflow <= 1'b1;
                            end else begin
                                o_We   <= 1'b1;
                                o_Data <= d_s3;
                            end
                        end
                        if (vs_rise) begin
                            state        <= S_DONE;
                            o_Frame_Done <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    o_Addr    <= '0;
                    addr_full <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/camera_capture.md
# camera_capture

Camera-side capture stage ahead of the frame RAM. It generates the sensor pixel clock (XLK) and synchronises the sensor's PLK/VS/HS/D[7:0] into the system clock domain. It writes each valid byte of one frame into RAM as a single-cycle write (address, data, write-enable), then reports frame completion. The UART send controller gates it with an enable so the RAM is never overwritten while a frame is being transmitted.

## Interface
- CLK_DIV, 2: XLK half-period in Clk cycles (XLK = Clk / (2·CLK_DIV)); legal range ≥1.
- ADDR_W, 15: RAM address width.
- MAX_BYTES, 11376: bytes stored per frame; must be ≤ 2^ADDR_W.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Enable  in  1  capture permitted (high = may arm/continue).
- i_PLK  in  1  sensor pixel clock (asynchronous to Clk).
- i_VS  in  1  sensor vertical sync; high = vertical blanking.
- i_HS  in  1  sensor horizontal reference; high = valid row data.
- i_D  in  8  sensor pixel byte.
- o_XLK  out  1  sensor master clock.
- o_Data  out  8  byte to RAM.
- o_Addr  out  ADDR_W  RAM write address.
- o_We  out  1  RAM write strobe, one Clk cycle per byte.
- o_Frame_Done  out  1  one-cycle pulse at end of a stored frame.
- o_Overflow  out  1  sticky: frame delivered more than MAX_BYTES bytes; cleared on the next arm.

## Operation
- Reset values: o_XLK=0, o_Data=0, o_Addr=0, o_We=0, o_Frame_Done=0, o_Overflow=0, state IDLE, all synchroniser flops 0.
- XLK: a counter runs from 0 to CLK_DIV−1; o_XLK toggles on wrap. XLK is free-running from reset and is independent of i_Enable.
- Synchronisers: 2-flop chains on i_PLK, i_VS, i_HS. i_D is registered alongside i_PLK's second stage so that data and clock stay aligned. A third register supplies previous values for edge detection.
- Pixel strobe: the synchronised PLK rises while the synchronised HS is high. This requires Clk ≥ 4× PLK.
- States:
  - IDLE: o_Addr held at 0. If i_Enable=1 and a VS falling edge is detected → CAPTURE; o_Overflow cleared on this transition.
  - CAPTURE: on each pixel strobe with o_Addr < MAX_BYTES: o_We=1, o_Data=sampled byte, o_Addr=current address; o_Addr increments on the following cycle. A strobe with count = MAX_BYTES writes nothing and sets o_Overflow. A VS rising edge → DONE.
  - DONE: o_Frame_Done=1 for exactly one cycle, o_Addr → 0; next state is IDLE.
- Abort: i_Enable=0 in CAPTURE → IDLE next cycle, o_Addr=0, no o_Frame_Done.
- Simultaneous events:
  - VS rising edge and pixel strobe in the same cycle: the byte is written first, then the transition to DONE.
  - i_Enable fall and VS rising edge in the same cycle: abort wins.
- A frame already in progress when the block is enabled is not captured; capture starts only at a VS falling edge.
- Address arithmetic is unsigned ADDR_W wide and never wraps: writes stop at MAX_BYTES−1.

## Timing
- Input-to-detect latency: 3 Clk from a pin edge to the internal edge pulse (2 sync stages + edge register).
- o_We is asserted on the cycle after edge detection, so a PLK rising edge reaches RAM write in 4 Clk. o_Data and o_Addr are valid in that same cycle.
- o_Frame_Done: 1 Clk after the VS-rise detect cycle (4 Clk from the pin edge).
- Re-arm: the earliest restart is the next VS falling edge after returning to IDLE.
- Mid-operation reset: all outputs return to reset values immediately (asynchronously); a partial frame is discarded.

## Configuration
- CAM_CAPTURE_ROW_SKIP_EN defined: a row toggle flips on each synchronised HS falling edge and resets to 0 at arm. Pixel strobes count only while the toggle is 0, so even rows (0, 2, 4…) are stored, giving half vertical resolution.
- Not defined: every row with HS high is stored; no toggle logic is present.

## Test plan
- Reset, then hold: CLK_DIV=2 → o_XLK period 4 Clk, first toggle 2 Clk after reset release; all other outputs 0.
- i_Enable=1; VS fall; 2 rows × 8 PLK rises with D=0..15 → 16 o_We pulses, Addr 0..15 carrying Data 0..15; VS rise → one o_Frame_Done pulse, Addr back to 0.
- MAX_BYTES=10 with 12 strobes → 10 writes (Addr 0..9); o_Overflow=1 held until the next arm.
- i_Enable dropped after 5 writes → IDLE; no o_Frame_Done; Addr=0; the next frame starts at Addr 0.
- Enable raised mid-frame (VS already low) → no writes until the next VS fall.
- With CAM_CAPTURE_ROW_SKIP_EN: 4 rows × 4 bytes → 8 writes, from rows 0 and 2 only.
